dpll_lock_ctrl: RTL and testbench

//  Acquisition/lock sequencer for the DPLL loop (PFD -> LPF -> DCO -> N-divider).

---
 rtl/dpll_pkg.sv | 17 +
 rtl/dpll_lock_ctrl_if.sv | 32 +++
 rtl/dpll_run_counter.sv | 32 +++
 rtl/dpll_lock_ctrl.sv | 159 +++++++++++++++
 tb/tb_dpll_lock_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/dpll_pkg.sv
// Shared types for the DPLL lock controller.
//   CTRL_W        width of the signed LPF control word
//   dpll_state_t  sequencer state encoding, also exported on state_o
package dpll_pkg;

  localparam int CTRL_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    ACQUIRE = 3'd2,
    TRACK   = 3'd3,
    LOCKED  = 3'd4,
    FAULT   = 3'd5
  } dpll_state_t;

endpackage

// File: rtl/dpll_lock_ctrl_if.sv
// Signal bundle between the DPLL loop and its lock controller.
//   enable, up, down, control : loop request, PFD pulses, signed LPF output
//   pfd_en, lpf_clr, gain_fine: loop actuation from the controller
//   locked, lock_lost, fault  : status (lock level, loss pulse, sticky timeout)
//   state_o                   : controller state for debug
// master drives the loop side, slave is the controller.
interface dpll_lock_ctrl_if;
  import dpll_pkg::*;

  logic                     enable;
  logic                     up;
  logic                     down;
  logic signed [CTRL_W-1:0] control;
  logic                     pfd_en;
  logic                     lpf_clr;
  logic                     gain_fine;
  logic                     locked;
  logic                     lock_lost;
  logic                     fault;
  logic [2:0]               state_o;

  modport master (
    output enable, up, down, control,
    input  pfd_en, lpf_clr, gain_fine, locked, lock_lost, fault, state_o
  );

  modport slave (
    input  enable, up, down, control,
    output pfd_en, lpf_clr, gain_fine, locked, lock_lost, fault, state_o
  );

endinterface

// File: rtl/dpll_run_counter.sv
// Saturating run-length counter.
//   pll_clk, rst_n : clock, asynchronous active-low reset
//   clr            : force count to zero
//   inc            : run continues this cycle; a cycle without inc restarts the run
//   lim            : run length of interest (count saturates here)
//   hit            : this cycle completes a run of lim consecutive inc cycles
module dpll_run_counter #(
  parameter int W = 9
) (
  input  logic         pll_clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] lim,
  output logic         hit
);

  logic [W-1:0] cnt;

  assign hit = inc && (cnt >= lim - W'(1));

  always_ff @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !inc) begin
      cnt <= '0;
    end else if (cnt < lim) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/dpll_lock_ctrl.sv
// Acquisition / lock sequencer for the DPLL loop.
// Gates the PFD, holds the LPF in clear while idle, switches coarse/fine gain,
// qualifies lock with hysteresis, detects loss of lock and flags acquisition timeout.
//   pll_clk : DCO clock, all logic on posedge
//   rst_n   : asynchronous active-low reset
//   bus     : dpll_lock_ctrl_if slave (loop inputs in, actuation/status out)
// All outputs are registered and decoded from the next state, so they line up
// with state_o.
module dpll_lock_ctrl
  import dpll_pkg::*;
#(
  parameter int                       SETTLE_CYC  = 64,
  parameter int                       ACQ_QUIET   = 32,
  parameter int                       LOCK_QUIET  = 256,
  parameter int                       WIN_CYC     = 1024,
  parameter int                       UNLOCK_ERR  = 16,
  parameter int                       ACQ_TIMEOUT = 65535,
  parameter logic signed [CTRL_W-1:0] SAT_LIM     = 16'sd30000
) (
  input  logic             pll_clk,
  input  logic             rst_n,
  dpll_lock_ctrl_if.slave  bus
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int QW = $clog2(LOCK_QUIET + 1);
  localparam int AW = $clog2(ACQ_QUIET + 1);
  localparam int WW = $clog2(WIN_CYC);
  localparam int EW = $clog2(UNLOCK_ERR + 1);
  localparam int TW = $clog2(ACQ_TIMEOUT + 1);

  dpll_state_t   state, state_nx;
  logic          quiet, active, in_acq, chg;
  logic          q_hit, a_hit, tmo_hit, err_hit, sat_hit;
  logic [QW-1:0] q_lim;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [WW-1:0] win_cnt;
  logic [EW-1:0] err_cnt;

  // Magnitude in CTRL_W+1 bits so the most negative code maps to +2^(CTRL_W-1).
  function automatic logic [CTRL_W:0] abs_ext(input logic signed [CTRL_W-1:0] v);
    logic signed [CTRL_W:0] x;
    x = {v[CTRL_W-1], v};
    return x[CTRL_W] ? -x : x;
  endfunction

  assign quiet   = !bus.up && !bus.down;
  assign active  = bus.up || bus.down;
  assign in_acq  = (state == ACQUIRE) || (state == TRACK);
  assign chg     = (state_nx != state);
  assign q_lim   = (state == TRACK) ? QW'(LOCK_QUIET) : QW'(ACQ_QUIET);
  assign tmo_hit = in_acq && (tmo_cnt == TW'(ACQ_TIMEOUT - 1));
  assign err_hit = active && (err_cnt >= EW'(UNLOCK_ERR - 1));
  assign sat_hit = abs_ext(bus.control) >= {1'b0, SAT_LIM};

  // Quiet run serves both acquisition (ACQ_QUIET) and lock (LOCK_QUIET) thresholds;
  // any state change restarts both runs.
  dpll_run_counter #(.W(QW)) u_quiet_run (
    .pll_clk (pll_clk),
    .rst_n   (rst_n),
    .clr     (chg),
    .inc     (quiet && in_acq),
    .lim     (q_lim),
    .hit     (q_hit)
  );

  dpll_run_counter #(.W(AW)) u_active_run (
    .pll_clk (pll_clk),
    .rst_n   (rst_n),
    .clr     (chg),
    .inc     (active && (state == TRACK)),
    .lim     (AW'(ACQ_QUIET)),
    .hit     (a_hit)
  );

  // Next-state: enable low wins, then timeout, then normal progress.
  always_comb begin
    state_nx = state;
    if (!bus.enable) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    state_nx = SETTLE;
        SETTLE:  if (settle_cnt == SW'(SETTLE_CYC - 1)) state_nx = ACQUIRE;
        ACQUIRE: begin
          if (tmo_hit)    state_nx = FAULT;
          else if (q_hit) state_nx = TRACK;
        end
        TRACK: begin
          if (tmo_hit)    state_nx = FAULT;
          else if (q_hit) state_nx = LOCKED;
          else if (a_hit) state_nx = ACQUIRE;
        end
        LOCKED:  if (err_hit || sat_hit) state_nx = ACQUIRE;
        FAULT:   state_nx = FAULT;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Settle, timeout and loss-of-lock window counters
  always_ff @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      win_cnt    <= '0;
      err_cnt    <= '0;
    end else begin
      if (state != SETTLE) begin
        settle_cnt <= '0;
      end else if (settle_cnt != SW'(SETTLE_CYC)) begin
        settle_cnt <= settle_cnt + SW'(1);
      end

      // Timeout spans ACQUIRE and TRACK together, including TRACK->ACQUIRE fallbacks.
      if (!(in_acq && (state_nx == ACQUIRE || state_nx == TRACK))) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt != TW'(ACQ_TIMEOUT)) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end

      if (state != LOCKED || state_nx != LOCKED) begin
        win_cnt <= '0;
        err_cnt <= '0;
      end else if (win_cnt == WW'(WIN_CYC - 1)) begin
        win_cnt <= '0;
        err_cnt <= '0;
      end else begin
        win_cnt <= win_cnt + WW'(1);
        if (active && err_cnt != EW'(UNLOCK_ERR)) err_cnt <= err_cnt + EW'(1);
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.pfd_en    <= 1'b0;
      bus.lpf_clr   <= 1'b1;
      bus.gain_fine <= 1'b0;
      bus.locked    <= 1'b0;
      bus.lock_lost <= 1'b0;
      bus.fault     <= 1'b0;
    end else begin
      state         <= state_nx;
      bus.pfd_en    <= state_nx inside {ACQUIRE, TRACK, LOCKED};
      bus.lpf_clr   <= state_nx inside {IDLE, SETTLE, FAULT};
      bus.gain_fine <= state_nx inside {TRACK, LOCKED};
      bus.locked    <= (state_nx == LOCKED);
      bus.lock_lost <= (state == LOCKED) && (state_nx == ACQUIRE);
      bus.fault     <= (state_nx == FAULT);
    end
  end

  assign bus.state_o = state;

endmodule

// File: tb/tb_dpll_lock_ctrl.sv
// Bench for dpll_lock_ctrl: directed stimulus, a cycle model of the lock rules
// checked on every falling edge, and literal expectations at key milestones.
module tb_dpll_lock_ctrl;
  import dpll_pkg::*;

  localparam int SETTLE_CYC  = 64;
  localparam int ACQ_QUIET   = 32;
  localparam int LOCK_QUIET  = 256;
  localparam int WIN_CYC     = 1024;
  localparam int UNLOCK_ERR  = 16;
  localparam int ACQ_TIMEOUT = 65535;
  localparam int SAT_LIM     = 30000;

  logic pll_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 pll_clk = ~pll_clk;

  dpll_lock_ctrl_if bus();

  dpll_lock_ctrl dut (
    .pll_clk (pll_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: state plus the elapsed-time quantities the lock rules are phrased in.
  dpll_state_t ms = IDLE;
  int settle_age, acq_age, quiet_run, active_run, locked_age, cur_win, win_errs;
  logic exp_lost = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic mreset();
    ms = IDLE;
    settle_age = 0; acq_age = 0; quiet_run = 0; active_run = 0;
    locked_age = 0; cur_win = 0; win_errs = 0;
    exp_lost = 1'b0;
  endtask

  // {pfd_en, lpf_clr, gain_fine, locked, fault}
  function automatic logic [4:0] state_outs(input dpll_state_t s);
    case (s)
      SETTLE:  return 5'b01000;
      ACQUIRE: return 5'b10000;
      TRACK:   return 5'b10100;
      LOCKED:  return 5'b10110;
      FAULT:   return 5'b01001;
      default: return 5'b01000;
    endcase
  endfunction

  task automatic mstep();
    bit en = bus.enable;
    bit act = bus.up || bus.down;
    int c = bus.control;
    int mag = (c < 0) ? -c : c;
    dpll_state_t nxt = ms;
    exp_lost = 1'b0;
    if (!en) begin
      nxt = IDLE;
    end else begin
      case (ms)
        IDLE: nxt = SETTLE;
        SETTLE: begin
          settle_age++;
          if (settle_age == SETTLE_CYC) nxt = ACQUIRE;
        end
        ACQUIRE, TRACK: begin
          acq_age++;
          quiet_run  = act ? 0 : quiet_run + 1;
          active_run = act ? active_run + 1 : 0;
          if (acq_age >= ACQ_TIMEOUT) nxt = FAULT;
          else if (ms == ACQUIRE && quiet_run >= ACQ_QUIET) nxt = TRACK;
          else if (ms == TRACK && quiet_run >= LOCK_QUIET) nxt = LOCKED;
          else if (ms == TRACK && active_run >= ACQ_QUIET) nxt = ACQUIRE;
        end
        LOCKED: begin
          if (locked_age / WIN_CYC != cur_win) begin
            cur_win  = locked_age / WIN_CYC;
            win_errs = 0;
          end
          if (act) win_errs++;
          locked_age++;
          if (win_errs >= UNLOCK_ERR || mag >= SAT_LIM) begin
            nxt = ACQUIRE;
            exp_lost = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (nxt != ms) begin
      settle_age = 0; quiet_run = 0; active_run = 0;
      locked_age = 0; cur_win = 0; win_errs = 0;
    end
    if (!(nxt inside {ACQUIRE, TRACK})) acq_age = 0;
    ms = nxt;
  endtask

  // Inputs only change #1 after a rising edge, so at the falling edge they are
  // exactly what the next rising edge will sample.
  always @(negedge pll_clk) begin
    if (!rst_n) mreset();
    check("outputs",
          {23'd0, bus.pfd_en, bus.lpf_clr, bus.gain_fine, bus.locked, bus.fault,
           bus.lock_lost, bus.state_o},
          {23'd0, state_outs(ms), exp_lost, 3'(ms)});
    if (rst_n) mstep();
  end

  task automatic tick(input int n);
    repeat (n) @(posedge pll_clk);
    #1;
  endtask

  initial begin
    bus.enable = 1'b0; bus.up = 1'b0; bus.down = 1'b0; bus.control = '0;
    tick(3);
    check("reset_lpf_clr", 32'(bus.lpf_clr), 32'd1);
    check("reset_state", 32'(bus.state_o), 32'd0);
    check("reset_pfd_en", 32'(bus.pfd_en), 32'd0);
    rst_n = 1'b1;

    // Clean acquisition: SETTLE 64, TRACK 32 later, LOCKED 256 after that.
    bus.enable = 1'b1;
    tick(1);  check("t1_settle", 32'(bus.state_o), 32'd1);
    tick(63); check("t1_settle_end", 32'(bus.state_o), 32'd1);
    tick(1);  check("t1_acquire", 32'(bus.state_o), 32'd2);
    tick(31); check("t1_acq_end", 32'(bus.state_o), 32'd2);
    tick(1);  check("t1_track_gain", 32'(bus.gain_fine), 32'd1);
    tick(255); check("t1_not_locked", 32'(bus.locked), 32'd0);
    tick(1);  check("t1_locked", 32'(bus.locked), 32'd1);

    // Sixteen up pulses inside one window drop lock.
    for (int p = 0; p < 15; p++) begin
      bus.up = 1'b1; tick(1); bus.up = 1'b0; tick(9);
    end
    check("t3_still_locked", 32'(bus.locked), 32'd1);
    bus.up = 1'b1; tick(1); bus.up = 1'b0;
    check("t3_lock_lost", 32'(bus.lock_lost), 32'd1);
    check("t3_acquire", 32'(bus.state_o), 32'd2);
    tick(1);  check("t3_pulse_one_cycle", 32'(bus.lock_lost), 32'd0);
    tick(287); check("t3_relocked", 32'(bus.locked), 32'd1);

    // Fifteen pulses per window, several windows: errors never accumulate.
    for (int w = 0; w < 3; w++) begin
      for (int p = 0; p < 15; p++) begin
        bus.down = (p % 2 == 1); bus.up = 1'b1; tick(1);
        bus.up = 1'b0; bus.down = 1'b0; tick(59);
      end
      tick(WIN_CYC - 15 * 60);
    end
    check("t4_still_locked", 32'(bus.locked), 32'd1);

    // Saturation of the control word.
    bus.control = 16'sd29999;  tick(5); check("t5_pos_below", 32'(bus.locked), 32'd1);
    bus.control = -16'sd29999; tick(5); check("t5_neg_below", 32'(bus.locked), 32'd1);
    bus.control = -16'sd30000; tick(1);
    check("t5_sat_lost", 32'(bus.lock_lost), 32'd1);
    bus.control = '0; tick(288); check("t5_relock1", 32'(bus.locked), 32'd1);
    bus.control = -16'sd32768; tick(1);
    check("t5_min_lost", 32'(bus.lock_lost), 32'd1);
    check("t5_min_state", 32'(bus.state_o), 32'd2);
    bus.control = '0; tick(288); check("t5_relock2", 32'(bus.locked), 32'd1);

    // enable drop in LOCKED, then async reset in TRACK.
    bus.enable = 1'b0; tick(1);
    check("t6_idle", 32'(bus.state_o), 32'd0);
    check("t6_no_pulse", 32'(bus.lock_lost), 32'd0);
    check("t6_unlocked", 32'(bus.locked), 32'd0);
    bus.enable = 1'b1; tick(107);
    check("t6_in_track", 32'(bus.state_o), 32'd3);
    rst_n = 1'b0; #1;
    check("t6_rst_state", 32'(bus.state_o), 32'd0);
    check("t6_rst_lpf_clr", 32'(bus.lpf_clr), 32'd1);
    check("t6_rst_gain", 32'(bus.gain_fine), 32'd0);
    bus.enable = 1'b0;
    tick(3); rst_n = 1'b1; tick(2);

    // Acquisition never quiet long enough: timeout into FAULT.
    bus.enable = 1'b1;
    for (int c = 1; c <= 65600; c++) begin
      bus.up = (c % 20 == 0);
      tick(1);
      if (c == 65599) check("t2_no_fault_yet", 32'(bus.fault), 32'd0);
    end
    bus.up = 1'b0;
    check("t2_fault", 32'(bus.fault), 32'd1);
    check("t2_fault_state", 32'(bus.state_o), 32'd5);
    tick(10); check("t2_fault_sticky", 32'(bus.fault), 32'd1);
    bus.enable = 1'b0; tick(1);
    check("t2_fault_clear", 32'(bus.fault), 32'd0);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
